// File: rtl/io_input_scan_ctrl_if.sv
// CPU-side I/O read/write window of the input scan controller.
// master = CPU / bus side, slave = scan controller.
interface io_input_scan_ctrl_if;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        irq;

  modport master (
    output addr, rd_en, wr_en, io_write_data,
    input  io_read_data, irq
  );

  modport slave (
    input  addr, rd_en, wr_en, io_write_data,
    output io_read_data, irq
  );
endinterface

// File: rtl/io_input_scan_ctrl.sv
// Round-robin scan and debounce of three 32-bit input ports.
// A prescaled tick starts one IDLE->SAMPLE->COMPARE->COMMIT pass on the
// current port; a value commits after DEB_CNT equal samples, raising a
// sticky change flag that feeds a maskable, registered interrupt.
module io_input_scan_ctrl #(
  parameter int SCAN_DIV = 16,
  parameter int DEB_CNT  = 3
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  input  logic [31:0] in_port2,
  io_input_scan_ctrl_if.slave bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_MAX    = 4'(DEB_CNT);

  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, COMPARE = 2'd2, COMMIT = 2'd3} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg;
  logic          tick;
  logic          tick_pend_reg;
  logic [1:0]    port_reg;
  logic [31:0]   samp_reg;
  logic [31:0]   in_sel;
  logic          scan_start, do_sample, do_compare, do_commit;
  logic [31:0]   stable_w [3];
  logic [2:0]    chg_w;
  logic [2:0]    rd_clr;
  logic [2:0]    mask_reg;
  logic          irq_reg;
  logic [5:0]    word;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign word        = bus.addr[7:2];
  assign tick        = (presc_reg == PRESC_LAST);
  assign unused_bits = ^{bus.addr[31:8], bus.addr[1:0], bus.io_write_data[31:3]};

  // Free-running prescaler; tick marks its last count.
  always_ff @(posedge io_clk) begin
    if (reset || tick) presc_reg <= '0;
    else               presc_reg <= presc_reg + PW'(1);
  end

  // FSM state, single-entry pending tick and round-robin port pointer.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      tick_pend_reg <= 1'b0;
      port_reg      <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (scan_start)                    tick_pend_reg <= 1'b0;
      else if (tick && state_reg != IDLE) tick_pend_reg <= 1'b1;
      if (do_commit) port_reg <= (port_reg == 2'd2) ? 2'd0 : port_reg + 2'd1;
    end
  end

  // Next-state logic: one state per cycle, a pass starts on any tick.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick || tick_pend_reg) state_next = SAMPLE;
      SAMPLE:  state_next = COMPARE;
      COMPARE: state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state action strobes.
  always_comb begin
    scan_start = 1'b0;
    do_sample  = 1'b0;
    do_compare = 1'b0;
    do_commit  = 1'b0;
    case (state_reg)
      IDLE:    scan_start = tick || tick_pend_reg;
      SAMPLE:  do_sample  = 1'b1;
      COMPARE: do_compare = 1'b1;
      COMMIT:  do_commit  = 1'b1;
      default: ;
    endcase
  end

  // Select the raw input of the port being scanned.
  always_comb begin
    case (port_reg)
      2'd0:    in_sel = in_port0;
      2'd1:    in_sel = in_port1;
      2'd2:    in_sel = in_port2;
      default: in_sel = 32'h0;
    endcase
  end

  // Raw inputs are captured only in SAMPLE.
  always_ff @(posedge io_clk) begin
    if (reset)          samp_reg <= 32'h0;
    else if (do_sample) samp_reg <= in_sel;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_port
      logic [31:0] cand_reg;
      logic [31:0] stable_reg;
      logic [3:0]  cnt_reg;
      logic        chg_reg;
      logic        sel;
      logic        commit_hit;

      assign sel        = (port_reg == 2'(gi));
      assign rd_clr[gi] = bus.rd_en && (word == 6'(gi));
      assign commit_hit = do_commit && sel && (cnt_reg == DEB_MAX) && (cand_reg != stable_reg);

      // Debounce candidate/count, commit, and sticky change flag (set beats read-clear).
      always_ff @(posedge io_clk) begin
        if (reset) begin
          cand_reg   <= 32'h0;
          stable_reg <= 32'h0;
          cnt_reg    <= 4'd0;
          chg_reg    <= 1'b0;
        end else begin
          if (do_compare && sel) begin
            if (samp_reg == cand_reg) begin
              if (cnt_reg < DEB_MAX) cnt_reg <= cnt_reg + 4'd1;
            end else begin
              cand_reg <= samp_reg;
              cnt_reg  <= 4'd1;
            end
          end
          if (commit_hit) begin
            stable_reg <= cand_reg;
            chg_reg    <= 1'b1;
          end else if (rd_clr[gi]) begin
            chg_reg <= 1'b0;
          end
        end
      end

      assign stable_w[gi] = stable_reg;
      assign chg_w[gi]    = chg_reg;
    end
  endgenerate

  // Mask register write and registered interrupt.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      mask_reg <= 3'b000;
      irq_reg  <= 1'b0;
    end else begin
      if (bus.wr_en && word == 6'd4) mask_reg <= bus.io_write_data[2:0];
      irq_reg <= |(chg_w & mask_reg);
    end
  end

  // Combinational read window.
  always_comb begin
    rdata = 32'h0;
    case (word)
      6'd0:    rdata = stable_w[0];
      6'd1:    rdata = stable_w[1];
      6'd2:    rdata = stable_w[2];
      6'd3:    rdata = {29'b0, chg_w};
      6'd4:    rdata = {29'b0, mask_reg};
      default: rdata = 32'h0;
    endcase
  end

  assign bus.io_read_data = rdata;
  assign bus.irq          = irq_reg;
endmodule

// File: tb/tb_io_input_scan_ctrl.sv
// Directed bench for io_input_scan_ctrl (SCAN_DIV=16, DEB_CNT=3).
// Timing reference: edge 0 is the first rising edge after reset release;
// tick n (1-based) is seen at edge 16n-1 and that visit commits at edge 16n+2.
module tb_io_input_scan_ctrl;
  logic        io_clk = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] in_port0 = 32'h0;
  logic [31:0] in_port1 = 32'h0;
  logic [31:0] in_port2 = 32'h0;
  int          errors = 0;
  int          checks = 0;

  io_input_scan_ctrl_if bus_if();

  io_input_scan_ctrl #(.SCAN_DIV(16), .DEB_CNT(3)) dut (
    .io_clk   (io_clk),
    .reset    (reset),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .in_port2 (in_port2),
    .bus      (bus_if.slave)
  );

  always #5 io_clk = ~io_clk;

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic adv(input int n);
    repeat (n) @(posedge io_clk);
    #1;
  endtask

  // Point the read window at a word and let the decode settle.
  task automatic set_word(input int w);
    bus_if.addr = 32'(w) << 2;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.rd_en = 1'b0;
    bus_if.wr_en = 1'b0;
    bus_if.addr = 32'h0;
    bus_if.io_write_data = 32'h0;
    adv(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_port0 = 32'hFFFF_FFFF;
    in_port1 = 32'hFFFF_FFFF;
    in_port2 = 32'hFFFF_FFFF;
    reset = 1'b1;
    bus_if.rd_en = 1'b0;
    bus_if.wr_en = 1'b0;
    bus_if.addr = 32'h0;
    bus_if.io_write_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      adv(1);
      checks++;
      if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL reset_irq cyc%0d: got %b want 0", i, bus_if.irq); end
      else $display("ok   reset_irq cyc%0d", i);
    end
    for (int w = 0; w < 5; w++) begin
      set_word(w);
      checks++;
      if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL reset_read w%0d: got %h want 00000000", w, bus_if.io_read_data); end
      else $display("ok   reset_read w%0d = %h", w, bus_if.io_read_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_debounce_commit();
    in_port0 = 32'hA5A5_0001; in_port1 = 32'h0; in_port2 = 32'h0;
    do_reset();
    adv(67);                   // after edge 66: second visit to port 0 done
    set_word(0);
    checks++;
    if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL deb_visit2: got %h want 00000000", bus_if.io_read_data); end
    else $display("ok   deb_visit2 stable0 = %h", bus_if.io_read_data);
    adv(47);                   // after edge 113: just before third-visit commit
    checks++;
    if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL deb_pre_commit: got %h want 00000000", bus_if.io_read_data); end
    else $display("ok   deb_pre_commit stable0 = %h", bus_if.io_read_data);
    adv(1);                    // after edge 114: committed on tick 7
    checks++;
    if (bus_if.io_read_data !== 32'hA5A5_0001) begin errors++; $display("FAIL deb_commit: got %h want a5a50001", bus_if.io_read_data); end
    else $display("ok   deb_commit stable0 = %h", bus_if.io_read_data);
    set_word(3);
    checks++;
    if (bus_if.io_read_data !== 32'h1) begin errors++; $display("FAIL deb_chg: got %h want 00000001", bus_if.io_read_data); end
    else $display("ok   deb_chg word3 = %h", bus_if.io_read_data);
    checks++;
    if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL deb_irq_masked: got %b want 0", bus_if.irq); end
    else $display("ok   deb_irq_masked");
  endtask

  task automatic test_glitch();
    in_port0 = 32'h0; in_port1 = 32'h2; in_port2 = 32'h0;
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      in_port1 = (n % 2 == 1) ? 32'h1 : 32'h2;
      adv(16);
    end
    set_word(1);
    checks++;
    if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL glitch_stable1: got %h want 00000000", bus_if.io_read_data); end
    else $display("ok   glitch_stable1 = %h", bus_if.io_read_data);
    set_word(3);
    checks++;
    if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL glitch_chg: got %h want 00000000", bus_if.io_read_data); end
    else $display("ok   glitch_chg word3 = %h", bus_if.io_read_data);
  endtask

  task automatic test_interrupt();
    in_port0 = 32'h9; in_port1 = 32'h55; in_port2 = 32'h0;
    do_reset();
    bus_if.addr = 32'h10;
    bus_if.io_write_data = 32'hFFFF_FFFA;   // mask bits 3'b010
    bus_if.wr_en = 1'b1;
    adv(1);                                 // after edge 0
    bus_if.wr_en = 1'b0;
    #1;
    checks++;
    if (bus_if.io_read_data !== 32'h2) begin errors++; $display("FAIL irq_mask_rd: got %h want 00000002", bus_if.io_read_data); end
    else $display("ok   irq_mask_rd = %h", bus_if.io_read_data);
    adv(116);                               // after edge 116: chg0 set, masked
    set_word(3);
    checks++;
    if (bus_if.io_read_data !== 32'h1) begin errors++; $display("FAIL irq_chg0: got %h want 00000001", bus_if.io_read_data); end
    else $display("ok   irq_chg0 word3 = %h", bus_if.io_read_data);
    checks++;
    if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_chg0_masked: got %b want 0", bus_if.irq); end
    else $display("ok   irq_chg0_masked");
    adv(14);                                // after edge 130: port 1 commits
    checks++;
    if (bus_if.io_read_data !== 32'h3) begin errors++; $display("FAIL irq_chg1: got %h want 00000003", bus_if.io_read_data); end
    else $display("ok   irq_chg1 word3 = %h", bus_if.io_read_data);
    checks++;
    if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b want 0", bus_if.irq); end
    else $display("ok   irq_lag irq still 0");
    adv(1);                                 // after edge 131
    checks++;
    if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", bus_if.irq); end
    else $display("ok   irq_rise");
    set_word(1);
    bus_if.rd_en = 1'b1;
    #1;
    checks++;
    if (bus_if.io_read_data !== 32'h55) begin errors++; $display("FAIL irq_read1: got %h want 00000055", bus_if.io_read_data); end
    else $display("ok   irq_read1 = %h", bus_if.io_read_data);
    adv(1);                                 // after edge 132: chg1 cleared
    bus_if.rd_en = 1'b0;
    set_word(3);
    checks++;
    if (bus_if.io_read_data !== 32'h1) begin errors++; $display("FAIL irq_clr: got %h want 00000001", bus_if.io_read_data); end
    else $display("ok   irq_clr word3 = %h", bus_if.io_read_data);
    checks++;
    if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL irq_drop_lag: got %b want 1", bus_if.irq); end
    else $display("ok   irq_drop_lag irq still 1");
    adv(1);                                 // after edge 133
    checks++;
    if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", bus_if.irq); end
    else $display("ok   irq_drop");
  endtask

  task automatic test_collision();
    in_port0 = 32'h0; in_port1 = 32'h0; in_port2 = 32'h7;
    do_reset();
    adv(146);                               // after edge 145: COMMIT of port 2 is next
    set_word(2);
    bus_if.rd_en = 1'b1;
    #1;
    checks++;
    if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL coll_old: got %h want 00000000", bus_if.io_read_data); end
    else $display("ok   coll_old stable2 = %h", bus_if.io_read_data);
    adv(1);                                 // after edge 146
    bus_if.rd_en = 1'b0;
    #1;
    checks++;
    if (bus_if.io_read_data !== 32'h7) begin errors++; $display("FAIL coll_new: got %h want 00000007", bus_if.io_read_data); end
    else $display("ok   coll_new stable2 = %h", bus_if.io_read_data);
    set_word(3);
    checks++;
    if (bus_if.io_read_data !== 32'h4) begin errors++; $display("FAIL coll_chg: got %h want 00000004", bus_if.io_read_data); end
    else $display("ok   coll_chg word3 = %h", bus_if.io_read_data);
  endtask

  task automatic test_midscan_reset();
    in_port0 = 32'h11; in_port1 = 32'h0; in_port2 = 32'h22;
    do_reset();
    adv(49);                                // after edge 48: port 2 in COMPARE
    reset = 1'b1;
    adv(2);
    reset = 1'b0;                           // new edge 0 follows
    for (int w = 0; w < 3; w++) begin
      set_word(w);
      checks++;
      if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL mrst_stable w%0d: got %h want 00000000", w, bus_if.io_read_data); end
      else $display("ok   mrst_stable w%0d = %h", w, bus_if.io_read_data);
    end
    set_word(0);
    adv(67);                                // after edge 66
    checks++;
    if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL mrst_visit2: got %h want 00000000", bus_if.io_read_data); end
    else $display("ok   mrst_visit2 stable0 = %h", bus_if.io_read_data);
    adv(47);                                // after edge 113
    checks++;
    if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL mrst_pre: got %h want 00000000", bus_if.io_read_data); end
    else $display("ok   mrst_pre stable0 = %h", bus_if.io_read_data);
    adv(1);                                 // after edge 114
    checks++;
    if (bus_if.io_read_data !== 32'h11) begin errors++; $display("FAIL mrst_commit0: got %h want 00000011", bus_if.io_read_data); end
    else $display("ok   mrst_commit0 stable0 = %h", bus_if.io_read_data);
    set_word(2);
    adv(31);                                // after edge 145
    checks++;
    if (bus_if.io_read_data !== 32'h0) begin errors++; $display("FAIL mrst_pre2: got %h want 00000000", bus_if.io_read_data); end
    else $display("ok   mrst_pre2 stable2 = %h", bus_if.io_read_data);
    adv(1);                                 // after edge 146
    checks++;
    if (bus_if.io_read_data !== 32'h22) begin errors++; $display("FAIL mrst_commit2: got %h want 00000022", bus_if.io_read_data); end
    else $display("ok   mrst_commit2 stable2 = %h", bus_if.io_read_data);
  endtask

  initial begin
    bus_if.addr = 32'h0;
    bus_if.rd_en = 1'b0;
    bus_if.wr_en = 1'b0;
    bus_if.io_write_data = 32'h0;
    test_reset();
    test_debounce_commit();
    test_glitch();
    test_interrupt();
    test_collision();
    test_midscan_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/io_input_scan_ctrl.md
Name: io_input_scan_ctrl

Overview:
- Scan controller for the three 32-bit input ports of the I/O input path.
- A prescaled scan tick sequences a small FSM that samples one port per tick in round-robin order and debounces each port.
- A port's value is committed to a stable register only after DEB_CNT consecutive equal samples.
- Committed changes raise per-port change flags and a maskable interrupt. The CPU reads stable values, status and mask through the existing word-addressed I/O read window.

Parameters:
- SCAN_DIV, 16: io_clk cycles per scan tick. Legal range is 4 or more.
- DEB_CNT, 3: consecutive equal samples required to commit a value. Legal range is 1 to 15.

Ports:
- io_clk  in  1  I/O clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_port0  in  32  raw external input, port 0.
- in_port1  in  32  raw external input, port 1.
- in_port2  in  32  raw external input, port 2.
- addr  in  32  CPU I/O address; only addr[7:2] is decoded.
- rd_en  in  1  CPU read strobe, one cycle per access.
- wr_en  in  1  CPU write strobe, one cycle per access.
- io_write_data  in  32  CPU write data.
- io_read_data  out  32  read data; combinational from addr[7:2] and current registers.
- irq  out  1  registered interrupt request.

Behaviour:
- Clock and reset: one clock, io_clk. reset is synchronous and active-high. Reset mid-scan aborts the scan with no partial commit.
- Reset values:
  - FSM = IDLE, port index p = 0, prescaler = 0, tick_pend = 0.
  - stable0..2 = 0, cand0..2 = 0, cnt0..2 = 0.
  - chg[2:0] = 0, mask[2:0] = 0, irq = 0.
  - io_read_data follows its decode; it is 0 for every word after reset.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = 1 in the cycle where prescaler = SCAN_DIV-1.
  - A tick seen outside IDLE sets tick_pend. tick_pend holds one pending tick only; it never accumulates.
- FSM (one state per cycle):
  - IDLE -> SAMPLE when tick or tick_pend is set; tick_pend is cleared on that transition.
  - SAMPLE: samp <= in_port[p]. Inputs are sampled only in this state.
  - COMPARE:
    - If samp == cand[p]: cnt[p] <= min(cnt[p]+1, DEB_CNT).
    - Otherwise: cand[p] <= samp and cnt[p] <= 1.
  - COMMIT:
    - If cnt[p] == DEB_CNT and cand[p] != stable[p]: stable[p] <= cand[p] and chg[p] <= 1.
    - Then p <= (p == 2) ? 0 : p+1, and go to IDLE.
- Scan timing: each port is visited every 3rd tick. A new constant input commits in the COMMIT of the DEB_CNT-th visit to that port. A glitch shorter than DEB_CNT visits never commits.
- Read map (addr[7:2]):
  - 0, 1, 2 -> stable0, stable1, stable2.
  - 3 -> {29'b0, chg[2:0]}.
  - 4 -> {29'b0, mask[2:0]}.
  - Any other word -> 32'h0.
- Read-to-clear: rd_en with word k in 0..2 clears chg[k] at the next edge. Reading word 3 does not clear anything.
- Write map: wr_en with word 4 sets mask <= io_write_data[2:0]. Writes to any other word are ignored.
- Interrupt: irq <= |(chg & mask), so irq lags the flag or mask change by one cycle.
- Simultaneous events:
  - COMMIT setting chg[k] in the same cycle as a read clearing chg[k]: the set wins and chg[k] = 1.
  - A read of stable[k] in the cycle its COMMIT occurs returns the old value.
  - A mask write takes effect on irq one cycle later.

Test Plan:
1. Hold reset 3 cycles with all inputs = 32'hFFFF_FFFF, then read words 0..4 -> every read returns 0 and irq = 0 throughout reset.
2. After reset, in_port0 = 32'hA5A5_0001 held constant, SCAN_DIV = 16, DEB_CNT = 3:
   - stable0 stays 0 through the 2nd visit to port 0.
   - stable0 = 32'hA5A5_0001 after the 3rd visit (tick 7).
   - Word 3 reads 3'b001.
3. Glitch rejection: in_port1 toggles between 32'h1 and 32'h2 on every visit to port 1 for 12 ticks -> stable1 stays 0 and chg[1] stays 0.
4. Interrupt:
   - Write mask = 3'b010, commit port 1 to 32'h55 -> irq rises one cycle after chg[1] sets.
   - Read word 1 with rd_en -> data 32'h55, chg[1] clears, irq drops one cycle later.
   - A chg[0] set with mask bit 0 = 0 never raises irq.
5. Collision: align rd_en on word 2 with the COMMIT cycle of port 2 (new value 32'h7) -> the read returns the old stable2, chg[2] = 1 afterwards, and stable2 = 32'h7.
6. Mid-scan reset: assert reset during COMPARE on port 2 -> after release p = 0, all cnt = 0 and all stable = 0, and the first scan tick occurs SCAN_DIV cycles later.
